snoop_bus_ctrl: RTL and testbench

Sequences one coherence transaction at a time on the shared snooping bus once the round-robin arbiter has issued a grant. It latches the granted CPU's command and address, broadcasts the snoop to every other cache, and collects their acknowledgements and shared/dirty responses. It then performs any required memory read or write and returns a one-cycle completion pulse to the requester. It drives the controller slot of the arbiter's busy vector (`busy[NUM_CPUS]`), so the arbiter issues no new grant while a transaction is in flight.

---
 rtl/snoop_bus_ctrl_pkg.sv | 28 ++
 rtl/snoop_collector.sv | 70 +++++++
 rtl/snoop_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the snooping bus controller: bus commands, FSM states and
// the default cache count.
package snoop_bus_ctrl_pkg;

    localparam int NUM_CPUS_DEFAULT = 4;

    typedef enum logic [1:0] {
        BUS_RD    = 2'd0,
        BUS_RDX   = 2'd1,
        BUS_UPGR  = 2'd2,
        BUS_FLUSH = 2'd3
    } bus_cmd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNOOP  = 3'd1,
        MEM_WB = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        DONE   = 3'd5
    } snoop_state_t;

    // Requester index width; a single-cache bus still carries a 1-bit index.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snoop_collector.sv
// Sticky collector of snoop acknowledgements and shared/dirty responses for
// one bus transaction, with the requester's own bit masked off.
module snoop_collector #(
    parameter int NUM_CPUS = 4,
    parameter int SRC_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [SRC_W-1:0]    src,
    input  logic [NUM_CPUS-1:0] ack,
    input  logic [NUM_CPUS-1:0] shared,
    input  logic [NUM_CPUS-1:0] dirty,
    output logic                all_acked,
    output logic                any_shared,
    output logic                any_dirty,
    output logic                multi_dirty
);

    logic [NUM_CPUS-1:0] mask;
    logic [NUM_CPUS-1:0] ack_in, shared_in, dirty_in, dirty_all;
    logic [NUM_CPUS-1:0] ack_q, ack_d;
    logic [NUM_CPUS-1:0] shared_q, shared_d;
    logic [NUM_CPUS-1:0] dirty_q, dirty_d;

    always_comb begin
        mask = '1;
        for (int i = 0; i < NUM_CPUS; i++) begin
            mask[i] = (SRC_W'(i) != src);
        end
    end

    // Shared/dirty are only meaningful alongside the same cache's ack.
    assign ack_in    = ack & mask & {NUM_CPUS{en}};
    assign shared_in = shared & ack_in;
    assign dirty_in  = dirty & ack_in;
    assign dirty_all = dirty_q | dirty_in;

    // Current-cycle responses are folded in so the FSM can leave SNOOP on
    // the same edge the last ack arrives.
    assign all_acked   = ((ack_q | ack_in) & mask) == mask;
    assign any_shared  = |(shared_q | shared_in);
    assign any_dirty   = |dirty_all;
    assign multi_dirty = en && ($countones(dirty_all) > 1);

    always_comb begin
        ack_d    = ack_q | ack_in;
        shared_d = shared_q | shared_in;
        dirty_d  = dirty_q | dirty_in;
        if (clear) begin
            ack_d    = '0;
            shared_d = '0;
            dirty_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= '0;
            shared_q <= '0;
            dirty_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            shared_q <= shared_d;
            dirty_q  <= dirty_d;
        end
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus transaction sequencer: latches a granted request, broadcasts
// the snoop, gathers responses, runs the memory access and signals completion.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int  NUM_CPUS  = snoop_bus_ctrl_pkg::NUM_CPUS_DEFAULT,
    parameter int  ADDR_W    = 32,
    parameter bit  ASSERT_EN = 1'b1,
    localparam int SRC_W     = src_w(NUM_CPUS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CPUS-1:0]              gnt,
    input  bus_cmd_t [NUM_CPUS-1:0]          req_cmd,
    input  logic [NUM_CPUS-1:0][ADDR_W-1:0]  req_addr,
    output logic                             snoop_valid,
    output bus_cmd_t                         snoop_cmd,
    output logic [ADDR_W-1:0]                snoop_addr,
    output logic [SRC_W-1:0]                 snoop_src,
    input  logic [NUM_CPUS-1:0]              snoop_ack,
    input  logic [NUM_CPUS-1:0]              snoop_shared,
    input  logic [NUM_CPUS-1:0]              snoop_dirty,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_resp,
    output logic [NUM_CPUS-1:0]              done,
    output logic                             done_shared,
    output logic                             ctrl_busy
);

    snoop_state_t          state_q, state_d;
    bus_cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic                  snoop_valid_q, snoop_valid_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [NUM_CPUS-1:0]   done_q, done_d;
    logic                  done_shared_q, done_shared_d;
    logic                  ctrl_busy_q, ctrl_busy_d;

    logic [SRC_W-1:0]      gnt_idx;
    logic                  coll_clear, coll_en;
    logic                  all_acked, any_shared, any_dirty, multi_dirty;
    logic                  err_gnt_busy, err_gnt_multi;

    // A malformed grant resolves to its lowest set bit.
    always_comb begin
        gnt_idx = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (gnt[i]) gnt_idx = SRC_W'(i);
        end
    end

    assign coll_en       = (state_q == SNOOP);
    assign err_gnt_busy  = (state_q != IDLE) && (|gnt);
    assign err_gnt_multi = (gnt & (gnt - 1'b1)) != '0;

    snoop_collector #(
        .NUM_CPUS (NUM_CPUS),
        .SRC_W    (SRC_W)
    ) u_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (coll_clear),
        .en          (coll_en),
        .src         (src_q),
        .ack         (snoop_ack),
        .shared      (snoop_shared),
        .dirty       (snoop_dirty),
        .all_acked   (all_acked),
        .any_shared  (any_shared),
        .any_dirty   (any_dirty),
        .multi_dirty (multi_dirty)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        src_d      = src_q;
        coll_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    src_d      = gnt_idx;
                    cmd_d      = req_cmd[gnt_idx];
                    addr_d     = req_addr[gnt_idx];
                    coll_clear = 1'b1;
                    state_d    = SNOOP;
                end
            end
            SNOOP: begin
                if (all_acked) begin
                    if (cmd_q == BUS_FLUSH)     state_d = MEM_WR;
                    else if (any_dirty)         state_d = MEM_WB;
                    else if (cmd_q == BUS_UPGR) state_d = DONE;
                    else                        state_d = MEM_RD;
                end
            end
            MEM_WB, MEM_RD, MEM_WR: begin
                if (mem_resp) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave on a flop.
        snoop_valid_d = (state_d == SNOOP);
        mem_req_d     = (state_d == MEM_WB) || (state_d == MEM_RD) || (state_d == MEM_WR);
        mem_we_d      = (state_d == MEM_WB) || (state_d == MEM_WR);
        ctrl_busy_d   = (state_d != IDLE);
        done_d        = '0;
        done_shared_d = 1'b0;
        if (state_d == DONE) begin
            done_d        = NUM_CPUS'(1) << src_d;
            done_shared_d = any_shared && (cmd_d == BUS_RD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_q         <= BUS_RD;
            addr_q        <= '0;
            src_q         <= '0;
            snoop_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            done_q        <= '0;
            done_shared_q <= 1'b0;
            ctrl_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            src_q         <= src_d;
            snoop_valid_q <= snoop_valid_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            done_q        <= done_d;
            done_shared_q <= done_shared_d;
            ctrl_busy_q   <= ctrl_busy_d;
        end
    end

    assign snoop_valid = snoop_valid_q;
    assign snoop_cmd   = cmd_q;
    assign snoop_addr  = addr_q;
    assign snoop_src   = src_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign done        = done_q;
    assign done_shared = done_shared_q;
    assign ctrl_busy   = ctrl_busy_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (ASSERT_EN && !rst) begin
            assert (!err_gnt_busy)  else $error("snoop_bus_ctrl: grant while transaction in flight");
            assert (!err_gnt_multi) else $error("snoop_bus_ctrl: grant not one-hot");
            assert (!multi_dirty)   else $error("snoop_bus_ctrl: more than one dirty responder");
        end
    end
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed table-driven bench for snoop_bus_ctrl with hand-built misuse and
// reset-abort sequences.
module tb_snoop_bus_ctrl;
    import snoop_bus_ctrl_pkg::*;

    localparam logic [1:0] C_RD = 2'd0, C_RDX = 2'd1, C_UP = 2'd2, C_FL = 2'd3;
    localparam logic [3:0] Z4 = 4'b0000;
    // ctl = {snoop_valid, mem_req, mem_we, done[3:0], done_shared, ctrl_busy}
    localparam logic [8:0] I_C  = 9'b0_0_0_0000_0_0;
    localparam logic [8:0] S_C  = 9'b1_0_0_0000_0_1;
    localparam logic [8:0] MR_C = 9'b0_1_0_0000_0_1;
    localparam logic [8:0] MW_C = 9'b0_1_1_0000_0_1;

    typedef struct {
        logic        rst;
        logic [3:0]  gnt;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  ack, shr, dty;
        logic        resp;
        logic [8:0]  ctl;
        logic [1:0]  ecmd;
        logic [1:0]  esrc;
        logic [31:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] gnt;
    bus_cmd_t [3:0] req_cmd;
    logic [3:0][31:0] req_addr;
    logic snoop_valid;
    bus_cmd_t snoop_cmd;
    logic [31:0] snoop_addr;
    logic [1:0] snoop_src;
    logic [3:0] snoop_ack, snoop_shared, snoop_dirty;
    logic mem_req, mem_we, mem_resp;
    logic [31:0] mem_addr;
    logic [3:0] done;
    logic done_shared, ctrl_busy;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    snoop_bus_ctrl #(
        .NUM_CPUS  (4),
        .ADDR_W    (32),
        .ASSERT_EN (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gnt          (gnt),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .snoop_valid  (snoop_valid),
        .snoop_cmd    (snoop_cmd),
        .snoop_addr   (snoop_addr),
        .snoop_src    (snoop_src),
        .snoop_ack    (snoop_ack),
        .snoop_shared (snoop_shared),
        .snoop_dirty  (snoop_dirty),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_resp     (mem_resp),
        .done         (done),
        .done_shared  (done_shared),
        .ctrl_busy    (ctrl_busy)
    );

    function automatic vec_t mk(input logic r, input logic [3:0] g, input logic [1:0] c,
                                input logic [31:0] a, input logic [3:0] ak, input logic [3:0] sh,
                                input logic [3:0] dy, input logic rs, input logic [8:0] ctl,
                                input logic [1:0] ec, input logic [1:0] es, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.gnt = g; v.cmd = c; v.addr = a;
        v.ack = ak; v.shr = sh; v.dty = dy; v.resp = rs;
        v.ctl = ctl; v.ecmd = ec; v.esrc = es; v.eaddr = ea;
        return v;
    endfunction

    // chk_err: 0 none, 1 expect grant-while-busy flag, 2 expect non-one-hot flag
    task automatic step(input vec_t v, input string name, input int chk_err);
        logic [8:0]  act_ctl;
        logic [67:0] act_lat, exp_lat;
        @(negedge clk);
        rst          = v.rst;
        gnt          = v.gnt;
        snoop_ack    = v.ack;
        snoop_shared = v.shr;
        snoop_dirty  = v.dty;
        mem_resp     = v.resp;
        for (int i = 0; i < 4; i++) begin
            req_cmd[i]  = bus_cmd_t'(v.cmd);
            req_addr[i] = v.addr;
        end
        #1;
        if (chk_err == 1) begin
            checks++;
            if (dut.err_gnt_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s gnt_busy_flag: got %b want 1", name, dut.err_gnt_busy);
            end
        end else if (chk_err == 2) begin
            checks++;
            if (dut.err_gnt_multi !== 1'b1) begin
                errors++;
                $display("FAIL %s gnt_multi_flag: got %b want 1", name, dut.err_gnt_multi);
            end
        end
        @(posedge clk);
        #1;
        act_ctl = {snoop_valid, mem_req, mem_we, done, done_shared, ctrl_busy};
        checks++;
        if (act_ctl !== v.ctl) begin
            errors++;
            $display("FAIL %s ctl{sv,mreq,mwe,done,dsh,busy}: got %b want %b", name, act_ctl, v.ctl);
        end
        act_lat = {snoop_cmd, snoop_src, snoop_addr, mem_addr};
        exp_lat = {v.ecmd, v.esrc, v.eaddr, v.eaddr};
        checks++;
        if (act_lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latched{cmd,src,addr,mem_addr}: got %h want %h", name, act_lat, exp_lat);
        end
    endtask

    initial begin
        rst = 1'b1; gnt = '0; snoop_ack = '0; snoop_shared = '0; snoop_dirty = '0;
        mem_resp = 1'b0; req_cmd = '0; req_addr = '0;

        // reset
        tbl.push_back(mk(1, Z4, C_RD, 0, Z4, Z4, Z4, 0, I_C, C_RD, 2'd0, 0));
        tbl.push_back(mk(1, Z4, C_RD, 0, Z4, Z4, Z4, 0, I_C, C_RD, 2'd0, 0));
        // upgrade by CPU1, all acks in first snoop cycle, CPU2 shared
        tbl.push_back(mk(0, 4'b0010, C_UP, 32'h40, Z4, Z4, Z4, 0, S_C, C_UP, 2'd1, 32'h40));
        tbl.push_back(mk(0, Z4, C_UP, 32'h40, 4'b1101, 4'b0100, Z4, 0, 9'b0_0_0_0010_0_1, C_UP, 2'd1, 32'h40));
        tbl.push_back(mk(0, Z4, C_UP, 32'h40, Z4, Z4, Z4, 0, I_C, C_UP, 2'd1, 32'h40));
        // read by CPU3, staggered acks, memory answers 4 cycles after entry
        tbl.push_back(mk(0, 4'b1000, C_RD, 32'h100, Z4, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, 4'b0001, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, Z4, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, 4'b0010, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, Z4, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, 4'b0100, Z4, Z4, 0, MR_C, C_RD, 2'd3, 32'h100));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, Z4, C_RD, 32'h100, Z4, Z4, Z4, 0, MR_C, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, Z4, Z4, Z4, 1, 9'b0_0_0_1000_0_1, C_RD, 2'd3, 32'h100));
        tbl.push_back(mk(0, Z4, C_RD, 32'h100, Z4, Z4, Z4, 0, I_C, C_RD, 2'd3, 32'h100));
        // read by CPU0, CPU1 dirty+shared -> write-back, shared completion
        tbl.push_back(mk(0, 4'b0001, C_RD, 32'h200, Z4, Z4, Z4, 0, S_C, C_RD, 2'd0, 32'h200));
        tbl.push_back(mk(0, Z4, C_RD, 32'h200, 4'b1110, 4'b0010, 4'b0010, 0, MW_C, C_RD, 2'd0, 32'h200));
        tbl.push_back(mk(0, Z4, C_RD, 32'h200, Z4, Z4, Z4, 1, 9'b0_0_0_0001_1_1, C_RD, 2'd0, 32'h200));
        tbl.push_back(mk(0, Z4, C_RD, 32'h200, Z4, Z4, Z4, 0, I_C, C_RD, 2'd0, 32'h200));
        // flush by CPU1; a sharer must not set done_shared
        tbl.push_back(mk(0, 4'b0010, C_FL, 32'h300, Z4, Z4, Z4, 0, S_C, C_FL, 2'd1, 32'h300));
        tbl.push_back(mk(0, Z4, C_FL, 32'h300, 4'b1101, 4'b0001, Z4, 0, MW_C, C_FL, 2'd1, 32'h300));
        tbl.push_back(mk(0, Z4, C_FL, 32'h300, Z4, Z4, Z4, 0, MW_C, C_FL, 2'd1, 32'h300));
        tbl.push_back(mk(0, Z4, C_FL, 32'h300, Z4, Z4, Z4, 1, 9'b0_0_0_0010_0_1, C_FL, 2'd1, 32'h300));
        tbl.push_back(mk(0, Z4, C_FL, 32'h300, Z4, Z4, Z4, 0, I_C, C_FL, 2'd1, 32'h300));
        // stray mem_resp in IDLE, then RDX by CPU2 with a sharer
        tbl.push_back(mk(0, Z4, C_FL, 32'h300, Z4, Z4, Z4, 1, I_C, C_FL, 2'd1, 32'h300));
        tbl.push_back(mk(0, 4'b0100, C_RDX, 32'h400, Z4, Z4, Z4, 0, S_C, C_RDX, 2'd2, 32'h400));
        tbl.push_back(mk(0, Z4, C_RDX, 32'h400, 4'b1011, 4'b1000, Z4, 0, MR_C, C_RDX, 2'd2, 32'h400));
        tbl.push_back(mk(0, Z4, C_RDX, 32'h400, Z4, Z4, Z4, 1, 9'b0_0_0_0100_0_1, C_RDX, 2'd2, 32'h400));
        tbl.push_back(mk(0, Z4, C_RDX, 32'h400, Z4, Z4, Z4, 0, I_C, C_RDX, 2'd2, 32'h400));

        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i), 0);

        // non-one-hot grant: lowest index (CPU1) wins
        step(mk(0, 4'b0110, C_UP, 32'h500, Z4, Z4, Z4, 0, S_C, C_UP, 2'd1, 32'h500), "multi_gnt", 2);
        step(mk(0, Z4, C_UP, 32'h500, 4'b1101, Z4, Z4, 0, 9'b0_0_0_0010_0_1, C_UP, 2'd1, 32'h500), "multi_gnt_done", 0);
        step(mk(0, Z4, C_UP, 32'h500, Z4, Z4, Z4, 0, I_C, C_UP, 2'd1, 32'h500), "multi_gnt_idle", 0);

        // misuse: requester's own ack/dirty ignored, grant during MEM_RD ignored
        step(mk(0, 4'b0100, C_RD, 32'h600, Z4, Z4, Z4, 0, S_C, C_RD, 2'd2, 32'h600), "mis_gnt", 0);
        step(mk(0, Z4, C_RD, 32'h600, 4'b0101, Z4, 4'b0100, 0, S_C, C_RD, 2'd2, 32'h600), "mis_selfack", 0);
        step(mk(0, Z4, C_RD, 32'h600, 4'b1010, Z4, Z4, 0, MR_C, C_RD, 2'd2, 32'h600), "mis_acks", 0);
        step(mk(0, 4'b0001, C_FL, 32'h999, Z4, Z4, Z4, 0, MR_C, C_RD, 2'd2, 32'h600), "mis_busy_gnt", 1);
        step(mk(0, Z4, C_RD, 32'h600, Z4, Z4, Z4, 1, 9'b0_0_0_0100_0_1, C_RD, 2'd2, 32'h600), "mis_done", 0);
        step(mk(0, Z4, C_RD, 32'h600, Z4, Z4, Z4, 0, I_C, C_RD, 2'd2, 32'h600), "mis_idle", 0);

        // reset during MEM_RD aborts; a fresh grant then completes
        step(mk(0, 4'b1000, C_RD, 32'h700, Z4, Z4, Z4, 0, S_C, C_RD, 2'd3, 32'h700), "rst_gnt", 0);
        step(mk(0, Z4, C_RD, 32'h700, 4'b0111, Z4, Z4, 0, MR_C, C_RD, 2'd3, 32'h700), "rst_memrd", 0);
        step(mk(1, Z4, C_RD, 32'h700, Z4, Z4, Z4, 0, I_C, C_RD, 2'd0, 0), "rst_abort", 0);
        step(mk(0, Z4, C_RD, 32'h700, Z4, Z4, Z4, 0, I_C, C_RD, 2'd0, 0), "rst_quiet", 0);
        step(mk(0, 4'b0001, C_UP, 32'h80, Z4, Z4, Z4, 0, S_C, C_UP, 2'd0, 32'h80), "rst_regnt", 0);
        step(mk(0, Z4, C_UP, 32'h80, 4'b1110, Z4, Z4, 0, 9'b0_0_0_0001_0_1, C_UP, 2'd0, 32'h80), "rst_redone", 0);
        step(mk(0, Z4, C_UP, 32'h80, Z4, Z4, Z4, 0, I_C, C_UP, 2'd0, 32'h80), "rst_reidle", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
